// File: rtl/chess_clock_core_if.sv
// Control and display bus of the N-player chess clock core.
// master drives the buttons/tick and reads the counters; slave is the core.
interface chess_clock_core_if #(
    parameter int unsigned NUM_PLAYERS = 2,
    parameter int unsigned MIN_W       = 7
);
    localparam int unsigned PW = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;

    logic                         tick;
    logic                         load;
    logic [MIN_W-1:0]             load_min;
    logic [5:0]                   load_sec;
    logic                         start;
    logic                         pause;
    logic                         turn_end;
    logic [PW-1:0]                active;
    logic [NUM_PLAYERS*MIN_W-1:0] min_all;
    logic [NUM_PLAYERS*6-1:0]     sec_all;
    logic [NUM_PLAYERS-1:0]       flag;
    logic [1:0]                   state;

    modport master (
        output tick, load, load_min, load_sec, start, pause, turn_end,
        input  active, min_all, sec_all, flag, state
    );

    modport slave (
        input  tick, load, load_min, load_sec, start, pause, turn_end,
        output active, min_all, sec_all, flag, state
    );
endinterface

// File: rtl/chess_clock_core.sv
// N-player countdown core: one min:sec counter per player, only the active one runs.
// Optional Fischer increment on turn_end is enabled by defining CHESS_INC_EN.
module chess_clock_core #(
    parameter int unsigned NUM_PLAYERS = 2,
    parameter int unsigned MIN_W       = 7,
    parameter int unsigned MAX_MIN     = 99,
    parameter int unsigned INC_SEC     = 5
) (
    input  logic                clk,
    input  logic                rst,
    chess_clock_core_if.slave   bus
);
    localparam int unsigned PW = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10,
        S_FLAG  = 2'b11
    } state_e;

    if (NUM_PLAYERS < 2 || MAX_MIN >= (1 << MIN_W) || INC_SEC > 59) begin : g_bad_param
        $error("chess_clock_core: illegal parameter combination");
    end

    state_e                 state_q;
    logic [PW-1:0]          active_q;
    logic [MIN_W-1:0]       min_q [NUM_PLAYERS];
    logic [5:0]             sec_q [NUM_PLAYERS];
    logic [NUM_PLAYERS-1:0] flag_q;

    logic [MIN_W-1:0]       dec_min_d, upd_min_d, load_min_d;
    logic [5:0]             dec_sec_d, upd_sec_d, load_sec_d;
    logic                   hit_zero_d;
    logic                   cur_zero_d;
    logic [PW-1:0]          next_active_d;

    // Next value of the active channel: tick decrement, then optional increment.
    always_comb begin
        dec_min_d = min_q[active_q];
        dec_sec_d = sec_q[active_q];
        if (bus.tick) begin
            if (sec_q[active_q] != 6'd0) begin
                dec_sec_d = sec_q[active_q] - 6'd1;
            end else if (min_q[active_q] != '0) begin
                dec_min_d = min_q[active_q] - MIN_W'(1);
                dec_sec_d = 6'd59;
            end
        end
        hit_zero_d = bus.tick && (dec_min_d == '0) && (dec_sec_d == 6'd0);
        cur_zero_d = (min_q[active_q] == '0) && (sec_q[active_q] == 6'd0);
        upd_min_d  = dec_min_d;
        upd_sec_d  = dec_sec_d;
`ifdef CHESS_INC_EN
        if (bus.turn_end) begin
            if ((7'(dec_sec_d) + 7'(INC_SEC)) >= 7'd60) begin
                if (dec_min_d >= MIN_W'(MAX_MIN)) begin
                    upd_min_d = MIN_W'(MAX_MIN);
                    upd_sec_d = 6'd59;
                end else begin
                    upd_min_d = dec_min_d + MIN_W'(1);
                    upd_sec_d = 6'(7'(dec_sec_d) + 7'(INC_SEC) - 7'd60);
                end
            end else begin
                upd_sec_d = 6'(7'(dec_sec_d) + 7'(INC_SEC));
            end
        end
`endif
        next_active_d = (active_q == PW'(NUM_PLAYERS - 1)) ? '0 : active_q + PW'(1);
        load_min_d    = (bus.load_min > MIN_W'(MAX_MIN)) ? MIN_W'(MAX_MIN) : bus.load_min;
        load_sec_d    = (bus.load_sec > 6'd59) ? 6'd59 : bus.load_sec;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            active_q <= '0;
            flag_q   <= '0;
            for (int i = 0; i < NUM_PLAYERS; i++) begin
                min_q[i] <= '0;
                sec_q[i] <= 6'd0;
            end
        end else if (bus.load) begin
            state_q  <= S_IDLE;
            active_q <= '0;
            flag_q   <= '0;
            for (int i = 0; i < NUM_PLAYERS; i++) begin
                min_q[i] <= load_min_d;
                sec_q[i] <= load_sec_d;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        if (cur_zero_d) begin
                            state_q          <= S_FLAG;
                            flag_q[active_q] <= 1'b1;
                        end else begin
                            state_q <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    // Reaching 0:00 on this edge overrides increment, switch and pause.
                    if (hit_zero_d) begin
                        min_q[active_q]  <= dec_min_d;
                        sec_q[active_q]  <= dec_sec_d;
                        flag_q[active_q] <= 1'b1;
                        state_q          <= S_FLAG;
                    end else begin
                        min_q[active_q] <= upd_min_d;
                        sec_q[active_q] <= upd_sec_d;
                        if (bus.turn_end) begin
                            active_q <= next_active_d;
                        end
                        if (bus.pause) begin
                            state_q <= S_PAUSE;
                        end
                    end
                end
                S_PAUSE: begin
                    if (bus.start) begin
                        state_q <= S_RUN;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    for (genvar i = 0; i < NUM_PLAYERS; i++) begin : g_out
        assign bus.min_all[i*MIN_W +: MIN_W] = min_q[i];
        assign bus.sec_all[i*6 +: 6]         = sec_q[i];
    end
    assign bus.active = active_q;
    assign bus.flag   = flag_q;
    assign bus.state  = state_q;

endmodule

// File: tb/tb_chess_clock_core.sv
// Bench for chess_clock_core: seconds-remaining reference model, directed scenarios, random stimulus.
module tb_chess_clock_core;
    localparam int unsigned N    = 2;
    localparam int unsigned MW   = 7;
    localparam int unsigned MAXM = 99;
`ifdef CHESS_INC_EN
    localparam int          INC  = 5;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    chess_clock_core_if #(.NUM_PLAYERS(N), .MIN_W(MW)) bus ();

    chess_clock_core #(
        .NUM_PLAYERS(N), .MIN_W(MW), .MAX_MIN(MAXM), .INC_SEC(5)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model: each channel is just a count of seconds remaining.
    int m_rem [N];
    int m_act;
    int m_st;
    bit m_flag [N];

    int n_checks = 0;
    int n_fail   = 0;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                m_rem[i]  = 0;
                m_flag[i] = 1'b0;
            end
            m_act = 0;
            m_st  = 0;
        end else if (bus.load) begin
            for (int i = 0; i < N; i++) begin
                m_rem[i]  = ((int'(bus.load_min) > MAXM) ? MAXM : int'(bus.load_min)) * 60
                          + ((int'(bus.load_sec) > 59) ? 59 : int'(bus.load_sec));
                m_flag[i] = 1'b0;
            end
            m_act = 0;
            m_st  = 0;
        end else begin
            case (m_st)
                0: if (bus.start) begin
                    if (m_rem[m_act] == 0) begin
                        m_flag[m_act] = 1'b1;
                        m_st = 3;
                    end else begin
                        m_st = 1;
                    end
                end
                1: begin
                    bit flagged_now;
                    flagged_now = 1'b0;
                    if (bus.tick) begin
                        if (m_rem[m_act] > 0) m_rem[m_act] = m_rem[m_act] - 1;
                        if (m_rem[m_act] == 0) begin
                            m_flag[m_act] = 1'b1;
                            m_st = 3;
                            flagged_now = 1'b1;
                        end
                    end
                    if (!flagged_now) begin
                        if (bus.turn_end) begin
`ifdef CHESS_INC_EN
                            m_rem[m_act] = m_rem[m_act] + INC;
                            if (m_rem[m_act] > MAXM * 60 + 59) m_rem[m_act] = MAXM * 60 + 59;
`endif
                            m_act = (m_act + 1) % N;
                        end
                        if (bus.pause) m_st = 2;
                    end
                end
                2: if (bus.start) m_st = 1;
                default: ;
            endcase
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int dmin(input int ch);
        logic [N*MW-1:0] v;
        v = bus.min_all;
        return int'(v[ch*MW +: MW]);
    endfunction

    function automatic int dsec(input int ch);
        logic [N*6-1:0] v;
        v = bus.sec_all;
        return int'(v[ch*6 +: 6]);
    endfunction

    task automatic compare_all();
        chk("active", int'(bus.active), m_act);
        chk("state", int'(bus.state), m_st);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("min[%0d]", i), dmin(i), m_rem[i] / 60);
            chk($sformatf("sec[%0d]", i), dsec(i), m_rem[i] % 60);
            chk($sformatf("flag[%0d]", i), int'(bus.flag[i]), int'(m_flag[i]));
        end
    endtask

    // One cycle: check outputs against the model, then drive the next inputs.
    task automatic step(input bit t, input bit l, input bit s, input bit p, input bit te);
        @(negedge clk);
        compare_all();
        bus.tick     = t;
        bus.load     = l;
        bus.start    = s;
        bus.pause    = p;
        bus.turn_end = te;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_load(input int mm, input int ss);
        bus.load_min = MW'(mm);
        bus.load_sec = 6'(ss);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        bus.tick = 1'b0; bus.load = 1'b0; bus.start = 1'b0;
        bus.pause = 1'b0; bus.turn_end = 1'b0;
        bus.load_min = '0; bus.load_sec = '0;

        repeat (2) @(negedge clk);
        chk("rst_min_all", int'(bus.min_all), 0);
        chk("rst_sec_all", int'(bus.sec_all), 0);
        chk("rst_flag", int'(bus.flag), 0);
        chk("rst_active", int'(bus.active), 0);
        chk("rst_state", int'(bus.state), 0);
        rst = 1'b0;

        // Countdown to flag from 0:03
        do_load(0, 3);
        step(0, 0, 1, 0, 0);
        repeat (3) step(1, 0, 0, 0, 0);
        idle();
        chk("t2_ch0_sec", dsec(0), 0);
        chk("t2_flag", int'(bus.flag), 1);
        chk("t2_state", int'(bus.state), 3);
        chk("t2_ch1_sec", dsec(1), 3);

        // Turn passing from 5:00
        do_load(5, 0);
        step(0, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0);
        idle();
        chk("t3_ch0_min", dmin(0), 4);
        chk("t3_ch0_sec", dsec(0), 59);
        step(0, 0, 0, 0, 1);
        idle();
        chk("t3_active", int'(bus.active), 1);
        step(1, 0, 0, 0, 0);
        idle();
        chk("t3_ch1_sec", dsec(1), 59);
        chk("t3_ch0_sec_hold", dsec(0), 59);

        // Pause freezes, start resumes
        step(0, 0, 0, 1, 0);
        repeat (4) step(1, 0, 0, 0, 1);
        idle();
        chk("t4_state", int'(bus.state), 2);
        chk("t4_ch1_sec", dsec(1), 59);
        step(0, 0, 1, 1, 0);
        step(1, 0, 0, 0, 0);
        idle();
        chk("t4_run", int'(bus.state), 1);
        chk("t4_ch1_dec", dsec(1), 58);

        // Tick and turn_end together reaching 0:00
        do_load(0, 1);
        step(0, 0, 1, 0, 0);
        step(1, 0, 0, 0, 1);
        idle();
        chk("t6_flag", int'(bus.flag), 1);
        chk("t6_active", int'(bus.active), 0);
        chk("t6_state", int'(bus.state), 3);
        step(1, 0, 1, 0, 1);
        idle();
        chk("t6_frozen", dsec(0), 0);

        // Load saturation
        do_load(120, 63);
        idle();
        chk("sat_min", dmin(1), 99);
        chk("sat_sec", dsec(1), 59);
        step(0, 0, 1, 0, 0);
        idle();
        chk("idle_start_run", int'(bus.state), 1);

`ifdef CHESS_INC_EN
        do_load(2, 57);
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1);
        idle();
        chk("t5_inc_min", dmin(0), 3);
        chk("t5_inc_sec", dsec(0), 2);
        chk("t5_active", int'(bus.active), 1);
        do_load(99, 58);
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1);
        idle();
        chk("t5_sat_min", dmin(0), 99);
        chk("t5_sat_sec", dsec(0), 59);
`endif

        // Random traffic
        for (int c = 0; c < 4000; c++) begin
            bit l;
            l = ($urandom_range(0, 99) < 2);
            if (l) begin
                bus.load_min = ($urandom_range(0, 9) == 0) ? MW'($urandom_range(0, 127))
                                                            : MW'($urandom_range(0, 1));
                bus.load_sec = 6'($urandom_range(0, 63));
            end
            step(bit'($urandom_range(0, 99) < 45), l,
                 bit'($urandom_range(0, 99) < 10),
                 bit'($urandom_range(0, 99) < 5),
                 bit'($urandom_range(0, 99) < 15));
        end
        idle();
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
